// File: rtl/seq_detect_ctrl_pkg.sv
// Shared state encoding and default widths for the serial pattern detector run controller.
package seq_detect_ctrl_pkg;

   localparam int DEF_PAT_W = 8;
   localparam int DEF_CNT_W = 8;
   localparam int DEF_TMO_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_RUN  = 2'd2
   } state_e;

endpackage

// File: rtl/seq_detect_ctrl_shift_cmp.sv
// Window shift register, fill counter and masked pattern compare for the detector.
// The shifted flag marks windows that are fresh, so a stalled stream never re-matches.
module seq_detect_ctrl_shift_cmp
   import seq_detect_ctrl_pkg::*;
#(
   parameter int PAT_W = DEF_PAT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear_i,
   input  logic             shift_i,
   input  logic             bit_i,
   input  logic [PAT_W-1:0] pattern_i,
   input  logic [PAT_W-1:0] mask_i,
   output logic             windowEq_o,
   output logic             shifted_o,
   output logic             fillLast_o
);

   localparam int FILL_W = $clog2(PAT_W + 1);

   logic [PAT_W-1:0]  shreg_q, shreg_d;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic              shifted_q, shifted_d;

   // Oldest bit ends up in the MSB; the fill count saturates once the window is full.
   always_comb begin
      shreg_d   = shreg_q;
      fill_d    = fill_q;
      shifted_d = shift_i;
      if (clear_i) begin
         shreg_d   = '0;
         fill_d    = '0;
         shifted_d = 1'b0;
      end else if (shift_i) begin
         shreg_d = {shreg_q[PAT_W-2:0], bit_i};
         if (fill_q != FILL_W'(PAT_W)) begin
            fill_d = fill_q + FILL_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg_q   <= '0;
         fill_q    <= '0;
         shifted_q <= 1'b0;
      end else begin
         shreg_q   <= shreg_d;
         fill_q    <= fill_d;
         shifted_q <= shifted_d;
      end
   end

   assign windowEq_o = (((shreg_q ^ pattern_i) & mask_i) == '0);
   assign shifted_o  = shifted_q;
   assign fillLast_o = (fill_q == FILL_W'(PAT_W - 1));

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run controller: config capture, IDLE/ARM/RUN sequencing, match counting and idle timeout.
// Abort beats done, done beats timeout, and a hit in the same cycle beats a timeout.
module seq_detect_ctrl
   import seq_detect_ctrl_pkg::*;
#(
   parameter int PAT_W = DEF_PAT_W,
   parameter int CNT_W = DEF_CNT_W,
   parameter int TMO_W = DEF_TMO_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [PAT_W-1:0] cfg_pattern,
   input  logic [PAT_W-1:0] cfg_mask,
   input  logic [CNT_W-1:0] cfg_count,
   input  logic [TMO_W-1:0] cfg_timeout,
   input  logic             start,
   input  logic             abort,
   input  logic             a_valid,
   input  logic             a,
   output logic             match,
   output logic [CNT_W-1:0] match_cnt,
   output logic             busy,
   output logic             done,
   output logic             timeout
);

   state_e           state_q;
   logic [PAT_W-1:0] cfgPattern_q;
   logic [PAT_W-1:0] cfgMask_q;
   logic [CNT_W-1:0] cfgCount_q;
   logic [TMO_W-1:0] cfgTimeout_q;
   logic [TMO_W-1:0] timer_q, timer_d;
   logic [CNT_W-1:0] matchCnt_q, matchCnt_d;
   logic             match_q, done_q, timeout_q;

   logic inIdle, cfgAccept, startAccept, shiftEn;
   logic windowEq, shifted, fillLast;
   logic hit, lastMatch, timerExpire;

   assign inIdle      = (state_q == ST_IDLE);
   assign cfgAccept   = cfg_valid && inIdle;
   assign startAccept = start && !abort && inIdle;
   assign shiftEn     = a_valid && !inIdle;

   seq_detect_ctrl_shift_cmp #(
      .PAT_W (PAT_W)
   ) u_shift_cmp (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear_i    (startAccept),
      .shift_i    (shiftEn),
      .bit_i      (a),
      .pattern_i  (cfgPattern_q),
      .mask_i     (cfgMask_q),
      .windowEq_o (windowEq),
      .shifted_o  (shifted),
      .fillLast_o (fillLast)
   );

   // Only a freshly shifted full window in RUN may count as a hit.
   always_comb begin
      hit         = (state_q == ST_RUN) && shifted && windowEq;
      matchCnt_d  = (&matchCnt_q) ? matchCnt_q : matchCnt_q + CNT_W'(1);
      lastMatch   = (cfgCount_q != '0) && (matchCnt_q + CNT_W'(1) == cfgCount_q);
      timerExpire = (cfgTimeout_q != '0) && (timer_q == cfgTimeout_q - TMO_W'(1));
      timer_d     = timer_q + TMO_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cfgPattern_q <= '0;
         cfgMask_q    <= '0;
         cfgCount_q   <= '0;
         cfgTimeout_q <= '0;
         timer_q      <= '0;
         matchCnt_q   <= '0;
         match_q      <= 1'b0;
         done_q       <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         match_q   <= 1'b0;
         done_q    <= 1'b0;
         timeout_q <= 1'b0;

         if (cfgAccept) begin
            cfgPattern_q <= cfg_pattern;
            cfgMask_q    <= cfg_mask;
            cfgCount_q   <= cfg_count;
            cfgTimeout_q <= cfg_timeout;
         end

         unique case (state_q)
            ST_IDLE: begin
               if (startAccept) begin
                  state_q    <= ST_ARM;
                  timer_q    <= '0;
                  matchCnt_q <= '0;
               end
            end
            ST_ARM, ST_RUN: begin
               if (abort) begin
                  state_q <= ST_IDLE;
               end else if (hit) begin
                  match_q    <= 1'b1;
                  matchCnt_q <= matchCnt_d;
                  timer_q    <= '0;
                  if (lastMatch) begin
                     done_q  <= 1'b1;
                     state_q <= ST_IDLE;
                  end
               end else if (timerExpire) begin
                  timeout_q <= 1'b1;
                  state_q   <= ST_IDLE;
               end else begin
                  timer_q <= timer_d;
                  // The edge that shifts in the last window bit also enters RUN.
                  if ((state_q == ST_ARM) && shiftEn && fillLast) begin
                     state_q <= ST_RUN;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign cfg_ready = inIdle;
   assign busy      = !inIdle;
   assign match     = match_q;
   assign match_cnt = matchCnt_q;
   assign done      = done_q;
   assign timeout   = timeout_q;

endmodule
